// File: rtl/seq_transport_if.sv
//------------------------------------------------------------------------------
// Module   : seq_transport_if
// Brief    : Command/status bundle between a controller and seq_transport.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

interface seq_transport_if #(
  parameter int NUM_BEATS = 16
);
  localparam int BW = $clog2(NUM_BEATS);
  localparam int LW = BW + 1;

  logic          play;
  logic          pause;
  logic          stop;
  logic          step_req;
  logic          tempo_wr;
  logic [23:0]   tempo_val;
  logic [LW-1:0] loop_len;
  logic [BW-1:0] beat_count;
  logic          beat_tick;
  logic          running;
  logic [1:0]    state;

  modport master (
    output play, pause, stop, step_req, tempo_wr, tempo_val, loop_len,
    input  beat_count, beat_tick, running, state
  );

  modport slave (
    input  play, pause, stop, step_req, tempo_wr, tempo_val, loop_len,
    output beat_count, beat_tick, running, state
  );
endinterface

`default_nettype wire

// File: rtl/seq_transport.sv
//------------------------------------------------------------------------------
// Module   : seq_transport
// Brief    : Step-sequencer transport: play/pause/stop/step FSM, tempo divider
//            and loop-length aware beat counter.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module seq_transport #(
  parameter int CLK_FREQ      = 12_000_000,
  parameter int NUM_BEATS     = 16,
  // Default of CLK_FREQ/4 gives 3_000_000 at 12 MHz: a 4 s pattern of 16 steps
  parameter int DEFAULT_TICKS = CLK_FREQ / 4
) (
  input  logic              clk,
  input  logic              rst,
  seq_transport_if.slave    bus
);
  localparam int            BW       = $clog2(NUM_BEATS);
  localparam int            LW       = BW + 1;
  localparam logic [LW-1:0] FULL_LEN = LW'(NUM_BEATS);
  localparam logic [23:0]   DEF_TPS  = 24'(DEFAULT_TICKS);

  typedef enum logic [1:0] {
    ST_STOPPED = 2'd0,
    ST_PLAYING = 2'd1,
    ST_PAUSED  = 2'd2,
    ST_ILLEGAL = 2'd3
  } state_t;

  state_t        state_q,      state_d;
  logic [BW-1:0] beat_count_q, beat_count_d;
  logic          beat_tick_q,  beat_tick_d;
  logic          running_q,    running_d;
  logic [23:0]   tick_cnt_q,   tick_cnt_d;
  logic [23:0]   tps_q,        tps_d;

  logic [LW-1:0] eff_len;
  logic [BW-1:0] beat_next;
  logic          step_due;

  always_comb begin
    eff_len   = (bus.loop_len == '0 || bus.loop_len > FULL_LEN) ? FULL_LEN : bus.loop_len;
    // A loop shortened below the current position wraps on the next advance
    beat_next = ({1'b0, beat_count_q} >= (eff_len - 1'b1)) ? '0 : beat_count_q + 1'b1;
    step_due  = (tick_cnt_q >= (tps_q - 24'd1));
  end

  always_comb begin
    state_d      = state_q;
    beat_count_d = beat_count_q;
    beat_tick_d  = 1'b0;
    tick_cnt_d   = tick_cnt_q;
    tps_d        = tps_q;

    // The advance decision below always sees the old tempo
    if (bus.tempo_wr)
      tps_d = (bus.tempo_val == 24'd0) ? 24'd1 : bus.tempo_val;

    if (bus.stop) begin
      state_d      = ST_STOPPED;
      beat_count_d = '0;
      tick_cnt_d   = '0;
    end else begin
      case (state_q)
        ST_STOPPED, ST_PAUSED: begin
          if (bus.play) begin
            state_d = ST_PLAYING;
          end else if (bus.step_req) begin
            beat_count_d = beat_next;
            beat_tick_d  = 1'b1;
            tick_cnt_d   = '0;
          end
        end
        ST_PLAYING: begin
          if (!bus.play && bus.pause) begin
            state_d = ST_PAUSED;
          end else if (step_due) begin
            beat_count_d = beat_next;
            beat_tick_d  = 1'b1;
            tick_cnt_d   = '0;
          end else begin
            tick_cnt_d = tick_cnt_q + 24'd1;
          end
        end
        default: state_d = ST_STOPPED;
      endcase
    end

    running_d = (state_d == ST_PLAYING);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_STOPPED;
      beat_count_q <= '0;
      beat_tick_q  <= 1'b0;
      running_q    <= 1'b0;
      tick_cnt_q   <= '0;
      tps_q        <= DEF_TPS;
    end else begin
      state_q      <= state_d;
      beat_count_q <= beat_count_d;
      beat_tick_q  <= beat_tick_d;
      running_q    <= running_d;
      tick_cnt_q   <= tick_cnt_d;
      tps_q        <= tps_d;
    end
  end

  assign bus.beat_count = beat_count_q;
  assign bus.beat_tick  = beat_tick_q;
  assign bus.running    = running_q;
  assign bus.state      = state_q;

endmodule

`default_nettype wire

// File: doc/seq_transport.md
SEQ_TRANSPORT -- requirements
Module: seq_transport

Interface
REQ-001: Parameter CLK_FREQ, default 12_000_000, system clock frequency in Hz (informational; used for default tempo only).
REQ-002: Parameter NUM_BEATS, default 16, steps per pattern; power of two, at least 2.
REQ-003: Parameter DEFAULT_TICKS, default 3_000_000, clocks per step after reset (4 s pattern at 16 steps, 12 MHz).
REQ-004: Port clk, input, 1, single system clock; all logic on posedge.
REQ-005: Port rst, input, 1, asynchronous, active-high reset.
REQ-006: Port play, input, 1, one-cycle command: start or resume.
REQ-007: Port pause, input, 1, one-cycle command: freeze position.
REQ-008: Port stop, input, 1, one-cycle command: halt and rewind.
REQ-009: Port step_req, input, 1, one-cycle command: advance one step while not playing.
REQ-010: Port tempo_wr, input, 1, write strobe for tempo_val.
REQ-011: Port tempo_val, input, 24, new clocks-per-step value.
REQ-012: Port loop_len, input, $clog2(NUM_BEATS)+1, active pattern length; 0 or >NUM_BEATS means NUM_BEATS.
REQ-013: Port beat_count, output, $clog2(NUM_BEATS), current step index to the voice datapath.
REQ-014: Port beat_tick, output, 1, one-cycle pulse in the cycle beat_count changes.
REQ-015: Port running, output, 1, high only in PLAYING.
REQ-016: Port state, output, 2, 0=STOPPED, 1=PLAYING, 2=PAUSED.

Function
REQ-017: FSM states STOPPED, PLAYING, PAUSED; encoding 3 unused and SHALL return to STOPPED next cycle.
REQ-018: Command priority when several are high in one cycle: stop > play > pause > step_req.
REQ-019: stop from any state: next state STOPPED, beat_count=0, tick counter=0.
REQ-020: play from STOPPED or PAUSED: next state PLAYING, beat_count and tick counter unchanged; play in PLAYING is ignored.
REQ-021: pause in PLAYING: next state PAUSED, counter frozen; pause elsewhere ignored.
REQ-022: step_req in STOPPED or PAUSED: advance beat_count by one (with wrap), pulse beat_tick, reset tick counter to 0, state unchanged; ignored in PLAYING.
REQ-023: In PLAYING, tick counter increments each cycle; when counter >= ticks_per_step-1, counter <= 0, beat_count advances, beat_tick pulses that same cycle (registered).
REQ-024: Advance rule: if beat_count >= eff_len-1 then 0 else beat_count+1, eff_len per REQ-012; a shortened loop_len below current position wraps to 0 on next advance.
REQ-025: tempo_wr latches tempo_val into ticks_per_step next cycle; tempo_val=0 stored as 1 (one step per clock).
REQ-026: Tempo change does not clear tick counter; if counter already >= new ticks_per_step-1, advance occurs on the next PLAYING cycle.
REQ-027: tempo_wr coincident with any command: both take effect; advance decision in that cycle uses the old ticks_per_step.
REQ-028: beat_tick is high for exactly one cycle per advance; never high in the cycle after reset or on stop.
REQ-029: All outputs registered; command-to-output latency one clock.

Reset
REQ-030: rst asserted at any time (including mid-step): state=STOPPED, beat_count=0, beat_tick=0, running=0, tick counter=0, ticks_per_step=DEFAULT_TICKS, immediately and held while rst high.
REQ-031: After rst deasserts, block stays STOPPED until play or step_req.

Verification
REQ-032: NUM_BEATS=16, tempo_val=4, tempo_wr, play -> beat_tick every 4 cycles, beat_count 0,1,..15,0; running=1.
REQ-033: loop_len=5, playing at beat_count=9 -> next advance gives 0, then 0..4 repeating.
REQ-034: pause at beat_count=3 mid-step, wait 20 cycles, play -> remaining ticks resume, no beat_tick during pause, next count 4.
REQ-035: stop and play in same cycle while PAUSED at 7 -> STOPPED, beat_count=0, no beat_tick.
REQ-036: STOPPED, three step_req pulses -> beat_count 3, three beat_tick pulses; step_req while PLAYING -> no extra advance.
REQ-037: rst asserted mid-PLAYING at beat_count=11, tempo_val=0 written earlier -> all outputs 0, ticks_per_step=DEFAULT_TICKS after release.
